// File: rtl/reu_xfer_seq_if.sv
// Signal bundle between the REU transfer sequencer and its register file, C64 bus and REU RAM.
// The master modport is the sequencer's view of the bundle; the slave modport is the environment's view.
interface reu_xfer_seq_if;
   logic       ExecuteEN;
   logic       FF00DecodeEN;
   logic       FF00Write;
   logic [1:0] XferType;
   logic       Length1;
   logic       BA;
   logic       nDMA;
   logic       C64RD;
   logic       C64WR;
   logic [7:0] C64DIn;
   logic [7:0] C64DOut;
   logic       RAMRD;
   logic       RAMWR;
   logic [7:0] RAMDIn;
   logic [7:0] RAMDOut;
   logic       NextCA;
   logic       NextREUA;
   logic       VerifyErr;
   logic       XferDone;

   modport master (
      input  ExecuteEN, FF00DecodeEN, FF00Write, XferType, Length1, BA, C64DIn, RAMDIn,
      output nDMA, C64RD, C64WR, C64DOut, RAMRD, RAMWR, RAMDOut,
             NextCA, NextREUA, VerifyErr, XferDone
   );

   modport slave (
      output ExecuteEN, FF00DecodeEN, FF00Write, XferType, Length1, BA, C64DIn, RAMDIn,
      input  nDMA, C64RD, C64WR, C64DOut, RAMRD, RAMWR, RAMDOut,
             NextCA, NextREUA, VerifyErr, XferDone
   );
endinterface

// File: rtl/reu_xfer_seq.sv
// REU DMA transfer sequencer: owns the C64 bus from request until XferDone and moves bytes
// between C64 memory and REU RAM. Swap transfers exist only when REU_SWAP_EN is defined.
module reu_xfer_seq #(
   parameter int BA_SETTLE = 3
) (
   input  logic           PHI2,
   input  logic           nReset,
   reu_xfer_seq_if.master xfer_io
);

   localparam int            CW          = (BA_SETTLE < 2) ? 1 : $clog2(BA_SETTLE + 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(BA_SETTLE - 1);

   typedef enum logic [3:0] {
      IDLE,
      ARM,
      REQ,
      S_RD,
      S_WR,
      F_RD,
      F_WR,
`ifdef REU_SWAP_EN
      W_RC,
      W_RR,
      W_WC,
      W_WR,
`endif
      V_RD,
      V_CMP,
      DONE
   } state_e;

   state_e        state_q, state_d, first_beat;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    lat_a_q, lat_a_d;
   logic [7:0]    lat_b_q, lat_b_d;
   logic          armed_q, armed_d;

   logic          dma, c64_rd, c64_wr, ram_rd, ram_wr, step, verify_err, xfer_done;
   logic [7:0]    c64_dout, ram_dout;

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge PHI2 or negedge nReset) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lat_a_q <= 8'h00;
         lat_b_q <= 8'h00;
         armed_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_a_q <= lat_a_d;
         lat_b_q <= lat_b_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      case (xfer_io.XferType)
         2'b00:   first_beat = S_RD;
         2'b01:   first_beat = F_RD;
`ifdef REU_SWAP_EN
         2'b10:   first_beat = W_RC;
`else
         2'b10:   first_beat = DONE;
`endif
         default: first_beat = V_RD;
      endcase
   end

   // A finished transfer must see ExecuteEN low before IDLE accepts a new start.
   always_comb begin
      armed_d = armed_q;
      if (state_q == DONE)
         armed_d = 1'b0;
      else if (!xfer_io.ExecuteEN)
         armed_d = 1'b1;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_a_d    = lat_a_q;
      lat_b_d    = lat_b_q;
      dma        = 1'b0;
      c64_rd     = 1'b0;
      c64_wr     = 1'b0;
      ram_rd     = 1'b0;
      ram_wr     = 1'b0;
      c64_dout   = 8'h00;
      ram_dout   = 8'h00;
      step       = 1'b0;
      verify_err = 1'b0;
      xfer_done  = 1'b0;

      case (state_q)
         IDLE: begin
            if (armed_q && xfer_io.ExecuteEN)
               state_d = xfer_io.FF00DecodeEN ? ARM : REQ;
         end
         ARM: begin
            if (!xfer_io.ExecuteEN)
               state_d = IDLE;
            else if (xfer_io.FF00Write)
               state_d = REQ;
         end
         REQ: begin
            dma = 1'b1;
            if (!xfer_io.BA) begin
               cnt_d = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = first_beat;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // Beat states: BA low freezes state and latches and silences the bus.
         S_RD: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               c64_rd  = 1'b1;
               lat_a_d = xfer_io.C64DIn;
               state_d = S_WR;
            end
         end
         S_WR: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               ram_wr   = 1'b1;
               ram_dout = lat_a_q;
               step     = 1'b1;
               state_d  = xfer_io.Length1 ? DONE : S_RD;
            end
         end
         F_RD: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               ram_rd  = 1'b1;
               lat_a_d = xfer_io.RAMDIn;
               state_d = F_WR;
            end
         end
         F_WR: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               c64_wr   = 1'b1;
               c64_dout = lat_a_q;
               step     = 1'b1;
               state_d  = xfer_io.Length1 ? DONE : F_RD;
            end
         end
`ifdef REU_SWAP_EN
         W_RC: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               c64_rd  = 1'b1;
               lat_a_d = xfer_io.C64DIn;
               state_d = W_RR;
            end
         end
         W_RR: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               ram_rd  = 1'b1;
               lat_b_d = xfer_io.RAMDIn;
               state_d = W_WC;
            end
         end
         W_WC: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               c64_wr   = 1'b1;
               c64_dout = lat_b_q;
               state_d  = W_WR;
            end
         end
         W_WR: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               ram_wr   = 1'b1;
               ram_dout = lat_a_q;
               step     = 1'b1;
               state_d  = xfer_io.Length1 ? DONE : W_RC;
            end
         end
`endif
         V_RD: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               c64_rd  = 1'b1;
               ram_rd  = 1'b1;
               lat_a_d = xfer_io.C64DIn;
               lat_b_d = xfer_io.RAMDIn;
               state_d = V_CMP;
            end
         end
         V_CMP: begin
            dma = 1'b1;
            if (xfer_io.BA) begin
               step = 1'b1;
               if (lat_a_q != lat_b_q) begin
                  verify_err = 1'b1;
                  state_d    = DONE;
               end else begin
                  state_d = xfer_io.Length1 ? DONE : V_RD;
               end
            end
         end
         DONE: begin
            xfer_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The reset term lets the C64 bus go the instant nReset falls.
   assign xfer_io.nDMA      = ~(dma & nReset);
   assign xfer_io.C64RD     = c64_rd;
   assign xfer_io.C64WR     = c64_wr;
   assign xfer_io.C64DOut   = c64_dout;
   assign xfer_io.RAMRD     = ram_rd;
   assign xfer_io.RAMWR     = ram_wr;
   assign xfer_io.RAMDOut   = ram_dout;
   assign xfer_io.NextCA    = step;
   assign xfer_io.NextREUA  = step;
   assign xfer_io.VerifyErr = verify_err;
   assign xfer_io.XferDone  = xfer_done;

endmodule
